// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The request holds until a one-cycle imem_ready pulse carries the read data.
interface if_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: fetch PC, FETCH/DROP/HOLD request FSM and the IF/ID pipeline register.
// Redirects resolve in ID, and a word that arrives during an ID stall is parked in holdBuf.
module if_fetch_stage (
   input  logic                      clk,
   input  logic                      clrn,
   input  logic                      stallD,
   input  logic                      flushD,
   input  logic                      redirect,
   input  logic [31:0]               redirect_pc,
   if_fetch_stage_if.master          imem,
   output logic [31:0]               instrD,
   output logic [31:0]               pcplus4D,
   output logic                      validD,
   output logic [31:0]               pcF,
   output logic                      if_busy
);

   typedef enum logic [1:0] {FETCH, DROP, HOLD} stateT;

   stateT       state;
   logic [31:0] holdBuf;
   logic [31:0] pendPc;
   logic        staleResp;
   logic [31:0] pcPlus4;
   logic [31:0] target;

   assign pcPlus4        = pcF + 32'd4;
   assign target         = redirect_pc & ~32'd3;
   assign imem.imem_addr = pcF;
   assign imem.imem_req  = !clrn && (state != HOLD);
   assign if_busy        = ((state == FETCH) && !imem.imem_ready) || (state == DROP);

   always_ff @(posedge clk) begin
      if (clrn) begin
         state     <= FETCH;
         pcF       <= 32'd0;
         instrD    <= 32'd0;
         pcplus4D  <= 32'd0;
         validD    <= 1'b0;
         holdBuf   <= 32'd0;
         pendPc    <= 32'd0;
         // A DROP interrupted by reset still owes one response; swallow it afterwards.
         staleResp <= (state == DROP) && !imem.imem_ready;
      end else begin
         case (state)
            FETCH: begin
               if (imem.imem_ready && staleResp) begin
                  staleResp <= 1'b0;
                  if (!stallD) begin
                     instrD <= 32'd0;
                     validD <= 1'b0;
                  end
                  if (redirect) pcF <= target;
               end else if (imem.imem_ready) begin
                  if (!stallD) begin
                     instrD   <= imem.imem_rdata;
                     pcplus4D <= pcPlus4;
                     validD   <= 1'b1;
                  end
                  if (redirect) begin
                     pcF <= target;
                  end else if (stallD) begin
                     holdBuf <= imem.imem_rdata;
                     state   <= HOLD;
                  end else begin
                     pcF <= pcPlus4;
                  end
               end else begin
                  if (!stallD) begin
                     instrD <= 32'd0;
                     validD <= 1'b0;
                  end
                  if (redirect) begin
                     pendPc <= target;
                     state  <= DROP;
                  end
               end
            end
            DROP: begin
               if (redirect) pendPc <= target;
               if (imem.imem_ready) begin
                  pcF       <= redirect ? target : pendPc;
                  staleResp <= 1'b0;
                  state     <= FETCH;
               end
               if (!stallD) begin
                  instrD <= 32'd0;
                  validD <= 1'b0;
               end
            end
            HOLD: begin
               if (!stallD) begin
                  instrD   <= holdBuf;
                  pcplus4D <= pcPlus4;
                  validD   <= 1'b1;
               end
               if (redirect) begin
                  pcF   <= target;
                  state <= FETCH;
               end else if (!stallD) begin
                  pcF   <= pcPlus4;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
         // NOTE: the last non-blocking assignment in a block wins, so this flush overrides any IF/ID load above.
         if (flushD) begin
            instrD <= 32'd0;
            validD <= 1'b0;
         end
      end
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and clrn per codebase naming; clrn=1 on a rising clk edge resets the block.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  synchronous active-high reset.
REQ-004 stallD  input  1  ID stage stalled; IF/ID register holds.
REQ-005 flushD  input  1  next IF/ID contents forced to bubble.
REQ-006 redirect  input  1  branch/jump taken; resolved in ID.
REQ-007 redirect_pc  input  32  target address; bits [1:0] ignored and treated as 00.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  fetch address, equal to pcF.
REQ-010 imem_ready  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instrD  output  32  IF/ID instruction, which feeds the ID stage.
REQ-013 pcplus4D  output  32  IF/ID PC+4, which feeds the ID stage.
REQ-014 validD  output  1  instrD holds a real instruction, not a bubble.
REQ-015 pcF  output  32  current fetch PC.
REQ-016 if_busy  output  1  fetch not complete this cycle (hazard-unit input).

Function
REQ-017 The FSM SHALL have three states: FETCH, DROP and HOLD.
- FETCH: request outstanding.
- DROP: outstanding response is to be discarded.
- HOLD: word buffered while ID is stalled.
REQ-018 imem_req SHALL be 1 in FETCH and DROP and 0 in HOLD; imem_addr SHALL stay stable until imem_ready.
REQ-019 FETCH with imem_ready and !stallD SHALL, on the next edge, do the following.
- Load instrD=imem_rdata, pcplus4D=pcF+4, validD=1.
- Set pcF=pcF+4 and stay in FETCH.
- Result: one instruction per cycle at zero-wait memory.
REQ-020 FETCH with imem_ready and stallD SHALL capture imem_rdata into a hold buffer, hold IF/ID, leave pcF unchanged and go to HOLD.
REQ-021 FETCH without imem_ready SHALL do the following.
- If !stallD: load a bubble into IF/ID (instrD=0, validD=0, pcplus4D unchanged).
- If stallD: hold IF/ID.
- In both cases stay in FETCH.
REQ-022 HOLD with !stallD SHALL load the buffered word into IF/ID, set pcplus4D=pcF+4, set pcF=pcF+4 and go to FETCH; HOLD with stallD SHALL stay in HOLD.
REQ-023 redirect in FETCH with imem_ready SHALL do the following.
- Load IF/ID from imem_rdata as in REQ-019 (the delay-slot instruction is kept) unless stallD, in which case IF/ID holds and the word is discarded.
- Set pcF={redirect_pc[31:2],2'b00}.
- Stay in FETCH.
REQ-024 redirect in FETCH without imem_ready SHALL do the following.
- Latch the target into a pending register and go to DROP.
- Keep imem_addr at the old pcF.
REQ-025 DROP SHALL discard imem_rdata on imem_ready, load pcF from the pending register and go to FETCH; IF/ID loads a bubble when !stallD and holds otherwise.
REQ-026 A redirect during DROP SHALL overwrite the pending register (last redirect wins).
REQ-027 redirect in HOLD SHALL do the following.
- Load the buffered word into IF/ID if !stallD; otherwise discard it.
- Set pcF=target and go to FETCH.
REQ-028 flushD SHALL force IF/ID to a bubble (instrD=0, validD=0) on the next edge regardless of stallD, and SHALL not affect the pcF or FSM transitions.
REQ-029 Priority SHALL be clrn > flushD (IF/ID only) > stallD, and redirect > sequential PC.
REQ-030 pcF+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-031 if_busy SHALL be 1 when (FETCH and !imem_ready) or DROP, and 0 otherwise.

Reset
REQ-032 clrn SHALL set pcF=0x0000_0000, FSM=FETCH, instrD=0, pcplus4D=0, validD=0, and clear the hold buffer and pending register.
REQ-033 While clrn=1, imem_req SHALL be 0, and the first request SHALL issue in the cycle after clrn deasserts.
REQ-034 clrn asserted mid-DROP or mid-HOLD SHALL abandon the state, and any late imem_ready response SHALL be ignored.

Verification
REQ-035 Zero-wait stream: imem_ready=1 with words A,B,C and no stall -> instrD=A,B,C on consecutive cycles, pcplus4D=4,8,12, validD=1.
REQ-036 Stall capture: ready with word X while stallD=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; then stallD=0 -> instrD=X, pcF advances by 4.
REQ-037 Redirect in flight: redirect to 0x0000_0103 while waiting, ready 2 cycles later -> stale word dropped, then imem_addr=0x0000_0100, if_busy=1 throughout the drop.
REQ-038 Flush with stall: flushD=1 and stallD=1 -> next cycle validD=0, instrD=0, pcF unchanged.
REQ-039 Wrap: pcF=0xFFFF_FFFC fetched with ready -> pcplus4D=0x0000_0000, pcF=0.
REQ-040 Reset mid-DROP: clrn=1 for one cycle, then a late imem_ready arrives -> pcF=0, validD=0, and the first fetch address is 0.
